// File: rtl/shift_unit_mc.sv
// -----------------------------------------------------------------------------
// shift_unit_mc
//   Multicycle shifter for the multicycle datapath's ALU-result path. It shifts
//   rt by an immediate (shamt) or register (rs) amount, at most STEP bit
//   positions per clock, under a start / busy / done handshake.
//
//   Supported operations (op):
//     000 SLL   001 SLLV   - logical left, zero fill from the LSB
//     010 SRA   011 SRAV   - arithmetic right, fill with the sign of rt
//     100 SRL   101 SRLV   - logical right, zero fill from the MSB
//     110 ROTR  111 ROTRV  - rotate right
//   op[0] selects the amount source: 0 = shamt, 1 = rs[SHW-1:0].
//
// Ports
//   clk     in   1      clock, all state updates on the rising edge
//   reset   in   1      synchronous active-high reset, wins over everything
//   start   in   1      request, sampled only while idle
//   op      in   3      operation code (see above)
//   rt      in   WIDTH  value to shift
//   rs      in   WIDTH  variable amount source, only rs[SHW-1:0] is used
//   shamt   in   SHW    immediate amount
//   busy    out  1      high while shifting
//   done    out  1      one-cycle pulse, result valid
//   result  out  WIDTH  last result, held until the next operation finishes
//
// Operands, op and amount are captured on the accepting edge; the inputs may
// change freely afterwards. An amount of zero skips the shift phase entirely.
// -----------------------------------------------------------------------------
module shift_unit_mc #(
    parameter int  WIDTH = 32,
    parameter int  STEP  = 1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] rs,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // STEP widened by one bit so that STEP == WIDTH still compares correctly
    // against the remaining amount.
    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Operation class, i.e. op[2:1]
    localparam logic [1:0] OPC_SLL  = 2'b00;
    localparam logic [1:0] OPC_SRA  = 2'b01;
    localparam logic [1:0] OPC_SRL  = 2'b10;
    localparam logic [1:0] OPC_ROTR = 2'b11;

    state_t           state_r;
    state_t           state_nx_s;
    logic             busy_r;
    logic             done_r;
    logic             busy_nx_s;
    logic             done_nx_s;

    logic [WIDTH-1:0] acc_r;
    logic [SHW-1:0]   rem_r;
    logic [1:0]       opc_r;
    logic             sign_r;
    logic [WIDTH-1:0] result_r;

    logic [SHW-1:0]   amt_s;
    logic             last_s;
    logic [SHW-1:0]   k_s;
    logic [WIDTH-1:0] shifted_s;
    logic             rs_unused_s;

    // Shift val by k positions (0..STEP) according to the operation class.
    // fill is the sign bit captured at accept, used for arithmetic right.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] val,
        input logic [SHW-1:0]   k,
        input logic [1:0]       opc,
        input logic             fill
    );
        logic [2*WIDTH-1:0] wide;
        logic [WIDTH-1:0]   res;
        wide = {(2*WIDTH){1'b0}};
        res  = val;
        case (opc)
            OPC_SLL: begin
                res = val << k;
            end
            OPC_SRA: begin
                wide = {{WIDTH{fill}}, val} >> k;
                res  = wide[WIDTH-1:0];
            end
            OPC_SRL: begin
                res = val >> k;
            end
            OPC_ROTR: begin
                // Bits leaving the LSB come back in from the upper copy.
                wide = {val, val} >> k;
                res  = wide[WIDTH-1:0];
            end
            default: begin
                res = val;
            end
        endcase
        return res;
    endfunction

    // Only the low SHW bits of rs carry an amount; the rest is ignored.
    assign rs_unused_s = ^rs[WIDTH-1:SHW];

    // Amount source select and per-cycle step size.
    always_comb begin
        amt_s     = shamt;
        last_s    = 1'b0;
        k_s       = {SHW{1'b0}};
        if (op[0]) begin
            amt_s = rs[SHW-1:0];
        end else begin
            amt_s = shamt;
        end
        // This edge finishes the operation when what remains fits in one step.
        last_s = ({1'b0, rem_r} <= STEP_W);
        if (last_s) begin
            k_s = rem_r;
        end else begin
            k_s = STEP_W[SHW-1:0];
        end
        shifted_s = shift_step(acc_r, k_s, opc_r, sign_r);
    end

    // State register with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (amt_s == {SHW{1'b0}}) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_SHIFT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so busy/done come straight from flops.
    always_comb begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        case (state_nx_s)
            ST_SHIFT: begin
                busy_nx_s = 1'b1;
            end
            ST_DONE: begin
                done_nx_s = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
        endcase
    end

    // Datapath: capture on accept, shift while busy, publish on the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r    <= {WIDTH{1'b0}};
            rem_r    <= {SHW{1'b0}};
            opc_r    <= 2'b00;
            sign_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r  <= rt;
                        rem_r  <= amt_s;
                        opc_r  <= op[2:1];
                        sign_r <= rt[WIDTH-1];
                        // A zero amount goes straight to DONE with rt unchanged.
                        if (amt_s == {SHW{1'b0}}) begin
                            result_r <= rt;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_r <= shifted_s;
                    rem_r <= rem_r - k_s;
                    if (last_s) begin
                        result_r <= shifted_s;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    shift_unit_mc_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk    (clk),
        .reset  (reset),
        .busy   (busy_r),
        .done   (done_r),
        .result (result_r)
    );

endmodule

// -----------------------------------------------------------------------------
// shift_unit_mc_chk
//   Handshake properties of shift_unit_mc.
//
// Ports
//   clk, reset  clock and synchronous reset of the shifter
//   busy, done  handshake outputs under observation
//   result      result output under observation
// -----------------------------------------------------------------------------
module shift_unit_mc_chk #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    input logic             busy,
    input logic             done,
    input logic [WIDTH-1:0] result
);

    a_busy_done_excl: assert property (@(posedge clk) disable iff (reset)
        !(busy && done));

    a_done_single: assert property (@(posedge clk) disable iff (reset)
        done |=> !done);

    a_result_hold_in_shift: assert property (@(posedge clk) disable iff (reset)
        busy |=> (!busy || $stable(result)));

endmodule

// File: tb/tb_shift_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_mc
//   Two shifters (STEP=1 and STEP=4) share operands and are checked against a
//   plain-arithmetic reference model. Expected results and the cycle each done
//   is due are queued at issue time; a negedge monitor checks busy, done,
//   result timing and result hold every cycle.
// -----------------------------------------------------------------------------
module tb_shift_unit_mc;

    localparam int W   = 32;
    localparam int SHW = 5;

    typedef struct {
        logic [W-1:0] res;
        int           due;
        int           n;
        logic         has_spec;
        logic [W-1:0] spec;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start1, start4;
    logic [2:0]     op;
    logic [W-1:0]   rt, rs;
    logic [SHW-1:0] shamt;
    logic           busy1, done1, busy4, done4;
    logic [W-1:0]   result1, result4;

    int             cyc = 0;
    int             compared = 0;
    int             mismatched = 0;
    exp_t           sb [2][$];
    logic [W-1:0]   last_exp [2];

    shift_unit_mc #(.WIDTH(W), .STEP(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op), .rt(rt), .rs(rs),
        .shamt(shamt), .busy(busy1), .done(done1), .result(result1)
    );

    shift_unit_mc #(.WIDTH(W), .STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op), .rt(rt), .rs(rs),
        .shamt(shamt), .busy(busy4), .done(done4), .result(result4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int step_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Reference: shift rt by amt using plain arithmetic on the whole word.
    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] t, input int amt);
        logic [W-1:0] r;
        r = t;
        case (o[2:1])
            2'b00: r = t << amt;
            2'b01: r = $signed(t) >>> amt;
            2'b10: r = t >> amt;
            default: for (int i = 0; i < W; i++) r[i] = t[(i + amt) % W];
        endcase
        return r;
    endfunction

    function automatic logic [SHW-1:0] pick_amt();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'd0;
        if (r == 1) return 5'd31;
        return 5'($urandom);
    endfunction

    task automatic chk(input string nm, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s step%0d cycle %0d: got %h expected %h", nm, step_of(k), cyc, act, exp);
        end
    endtask

    // Monitor: compare each DUT's handshake and result against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                sb[k].delete();
                last_exp[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic         b, d, eb, ed;
                logic [W-1:0] r;
                exp_t         e;
                b  = (k == 0) ? busy1 : busy4;
                d  = (k == 0) ? done1 : done4;
                r  = (k == 0) ? result1 : result4;
                eb = 1'b0;
                ed = 1'b0;
                if (sb[k].size() != 0) begin
                    eb = (cyc >= sb[k][0].due - sb[k][0].n) && (cyc < sb[k][0].due);
                    ed = (cyc == sb[k][0].due);
                end
                chk("busy", k, W'(b), W'(eb));
                chk("done", k, W'(d), W'(ed));
                if (d && sb[k].size() != 0) begin
                    e = sb[k].pop_front();
                    chk("result", k, r, e.res);
                    if (e.has_spec) chk("spec_result", k, r, e.spec);
                    last_exp[k] = e.res;
                end else begin
                    if (!d) chk("hold", k, r, last_exp[k]);
                    if (sb[k].size() != 0 && cyc >= sb[k][0].due) e = sb[k].pop_front();
                end
            end
        end
    end

    task automatic scramble();
        op    = 3'($urandom);
        rt    = $urandom;
        rs    = $urandom;
        shamt = 5'($urandom);
    endtask

    // Issue one operation to both DUTs (both must be idle) and queue expectations.
    task automatic launch(input logic [2:0] o, input logic [W-1:0] t, input logic [W-1:0] s,
                          input logic [SHW-1:0] sh, input logic hs, input logic [W-1:0] sp);
        exp_t e;
        int   amt;
        op = o; rt = t; rs = s; shamt = sh;
        start1 = 1'b1;
        start4 = 1'b1;
        amt = o[0] ? int'(s[SHW-1:0]) : int'(sh);
        for (int k = 0; k < 2; k++) begin
            e.res      = model(o, t, amt);
            e.n        = (amt + step_of(k) - 1) / step_of(k);
            e.due      = cyc + 1 + e.n;
            e.has_spec = hs;
            e.spec     = sp;
            sb[k].push_back(e);
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
        scramble();
    endtask

    // Run until both DUTs are idle, poking start while they are not.
    task automatic run_idle();
        int guard;
        guard = 0;
        while ((busy1 || done1 || busy4 || done4) && guard < 60) begin
            start1 = (busy1 || done1) && ($urandom_range(0, 1) == 1);
            start4 = (busy4 || done4) && ($urandom_range(0, 1) == 1);
            scramble();
            @(posedge clk); #1;
            guard++;
        end
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic rand_op();
        logic [2:0]   o;
        logic [W-1:0] s;
        o = 3'($urandom);
        s = $urandom;
        s[SHW-1:0] = pick_amt();
        launch(o, $urandom, s, pick_amt(), 1'b0, '0);
        run_idle();
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
        op = '0; rt = '0; rs = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        launch(3'b000, 32'h0000_0001, $urandom, 5'd4, 1'b1, 32'h0000_0010);            run_idle();
        launch(3'b010, 32'h8000_0000, $urandom, 5'd31, 1'b1, 32'hFFFF_FFFF);           run_idle();
        launch(3'b100, 32'h8000_0000, $urandom, 5'd31, 1'b1, 32'h0000_0001);           run_idle();
        launch(3'b011, 32'hF000_0000, 32'h0000_0024, 5'($urandom), 1'b1, 32'hFF00_0000); run_idle();
        launch(3'b000, 32'hDEAD_BEEF, $urandom, 5'd0, 1'b1, 32'hDEAD_BEEF);            run_idle();
        launch(3'b111, 32'h1234_5678, 32'h0000_0008, 5'($urandom), 1'b1, 32'h7812_3456); run_idle();

        for (int i = 0; i < 40; i++) rand_op();

        // Reset in the middle of a long shift, with start poked while busy.
        launch(3'b000, $urandom | 32'h1, $urandom, 5'd20, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            start1 = 1'b1;
            start4 = 1'b1;
            scramble();
            @(posedge clk); #1;
        end
        start1 = 1'b0;
        start4 = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        for (int i = 0; i < 120; i++) rand_op();

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
